spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Shares the single SPI master (shared by external flash and RAM chip-selects) between two requesters: port 0 (bootloader) and port 1 (CPU memory interface). It grants ownership to one requester at a time and muxes that owner's command signals onto the SPI master. It never revokes ownership while a byte transfer is in flight, and forces a one-cycle chip-select turnaround between owners. A watchdog reclaims the bus from an owner that holds it idle too long.

## Interface
- TIMEOUT_CYCLES, default 1024: idle cycles an owner may hold the grant before forced release; must be ≥2.
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- reqN  in  1  (N=0,1) requester N wants the bus; level, held for the whole ownership
- gntN  out  1  requester N owns the bus
- txn_startN  in  1  one-cycle pulse, start a byte transfer
- data_txN  in  8  byte to send
- force_clockN  in  1  pulse, force SPI clock
- flash_ce_nN, ram_ce_nN  in  1  requester's chip selects, active low
- txn_doneN  out  1  spi_txn_done gated to the owner
- spi_data_rx_out  out  8  spi_data_rx broadcast to both ports, ungated
- spi_txn_start, spi_data_tx[8], spi_force_clock, spi_flash_ce_n, spi_ram_ce_n  out  to SPI master and pads
- spi_txn_done  in  1  master finished a byte; spi_data_rx  in  8
- timeout  out  1  one-cycle pulse, watchdog fired

## Operation
- States: IDLE, GRANT0, GRANT1, RELEASE. 2-bit state, gnt0/gnt1 decoded from state.
- IDLE:
  - No req: stay in IDLE.
  - One req: go to GRANTn.
  - Both reqs: apply the arbitration policy (see Configuration).
- GRANTn:
  - Shared outputs are driven combinationally from port n's inputs. txn_done goes to port n only.
  - busy register: set on accepted txn_startn, cleared on spi_txn_done.
  - Leave to RELEASE when reqn=0 and busy=0. If reqn drops while busy, hold the grant until spi_txn_done, then go to RELEASE on the next cycle.
- RELEASE: all CE_n=1, all gnt=0, start and force outputs 0. Always go to IDLE next.
- Non-granted outputs:
  - spi_txn_start=0, spi_data_tx=0x00, spi_force_clock=0, spi_flash_ce_n=1, spi_ram_ce_n=1.
  - Inputs from a non-owner are ignored.
- Watchdog:
  - Counter width is clog2(TIMEOUT_CYCLES+1).
  - Counter cleared on entry to GRANTn, and on the owner's txn_start, force_clock or spi_txn_done.
  - Increments each GRANTn cycle with busy=0 and frozen while busy=1, so an in-flight transfer is never cut.
  - Reaching TIMEOUT_CYCLES-1 while not busy: go to RELEASE, pulse timeout for 1 cycle.
  - The timed-out requester must drop and re-raise req to be re-granted. A per-port "stale" flag blocks a grant while the original req stays high and clears when req=0.
- Reset values: state IDLE, gnt0=gnt1=0, busy=0, counter=0, timeout=0, stale flags 0, last-owner=1. Shared outputs take their non-granted values immediately, because they are asynchronous via state.
- Reset mid-transfer: CE_n deasserts immediately. The SPI master is reset by the same rst_n.

## Timing
- reqn rising, sampled at edge k → gntn=1 after edge k (1-cycle grant latency). The owner may pulse txn_start the cycle gnt is seen.
- txn_start, data_tx, force_clock and CE pass through with zero latency (combinational mux on registered state).
- spi_txn_done → txn_doneN: zero latency.
- Release: reqn=0 sampled at edge m (not busy) → RELEASE after m, IDLE after m+1, earliest new grant after m+2. That gives ≥1 full cycle with both CE_n high between owners.
- txn_start and spi_txn_done in the same cycle: busy stays 1 (new transfer wins).

## Configuration
- SPI_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests in IDLE, grant the port that is not the last owner.
  - last-owner updates on each grant; reset value is 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties. The last-owner register is not implemented.

## Test plan
- Single requester: req1=1, three txn_start1 bytes 0x9F/0x00/0x00 with done after each → gnt1 one cycle after req, spi_data_tx tracks data_tx1, txn_done1 pulses 3×, txn_done0 stays 0, CE drops only when gnt1=1.
- Tie: req0=req1=1 from IDLE, each holds the bus 4 cycles → fixed priority: 0,0,0 while req0 held. With SPI_ARB_ROUND_ROBIN_EN: 0 then 1, with 2 idle cycles and both CE_n=1 between grants.
- Drop while busy: req0 falls 1 cycle after txn_start0, done arrives 8 cycles later → gnt0 held until done, RELEASE the next cycle.
- Watchdog, TIMEOUT_CYCLES=16: owner idles holding req → timeout pulse, gnt drop after 16 granted cycles. Re-grant only after req low→high. A transfer lasting 40 cycles does not time out.
- Async reset: rst_n low mid-transfer while GRANT1 and busy → gnt1, spi_txn_start and CE_n return to reset values without a clock edge. After release, behaviour matches power-up.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Two-port arbiter for a shared SPI master with chip-select turnaround and an idle watchdog.
// Optional SPI_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed port-0 priority.
module spi_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       req1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    input  logic       txn_start0_i,
    input  logic       txn_start1_i,
    input  logic [7:0] data_tx0_i,
    input  logic [7:0] data_tx1_i,
    input  logic       force_clock0_i,
    input  logic       force_clock1_i,
    input  logic       flash_ce_n0_i,
    input  logic       flash_ce_n1_i,
    input  logic       ram_ce_n0_i,
    input  logic       ram_ce_n1_i,
    output logic       txn_done0_o,
    output logic       txn_done1_o,
    output logic [7:0] spi_data_rx_o,
    output logic       spi_txn_start_o,
    output logic [7:0] spi_data_tx_o,
    output logic       spi_force_clock_o,
    output logic       spi_flash_ce_n_o,
    output logic       spi_ram_ce_n_o,
    input  logic       spi_txn_done_i,
    input  logic [7:0] spi_data_rx_i,
    output logic       timeout_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT0  = 2'd1,
        ST_GRANT1  = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       stale_q, stale_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic             last_q, last_d;
`endif

    logic       own_any, own_sel, own_req, own_start, own_force, pick1;
    logic [1:0] eff_req;

    assign own_any   = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign own_sel   = (state_q == ST_GRANT1);
    assign own_req   = own_sel ? req1_i : req0_i;
    assign own_start = own_any & (own_sel ? txn_start1_i : txn_start0_i);
    assign own_force = own_any & (own_sel ? force_clock1_i : force_clock0_i);
    assign eff_req   = {req1_i, req0_i} & ~stale_q;

    assign gnt0_o        = (state_q == ST_GRANT0);
    assign gnt1_o        = (state_q == ST_GRANT1);
    assign txn_done0_o   = gnt0_o & spi_txn_done_i;
    assign txn_done1_o   = gnt1_o & spi_txn_done_i;
    assign spi_data_rx_o = spi_data_rx_i;
    assign timeout_o     = timeout_q;

    // Shared SPI command mux; idle values whenever nobody owns the bus
    always_comb begin
        spi_txn_start_o   = 1'b0;
        spi_data_tx_o     = 8'h00;
        spi_force_clock_o = 1'b0;
        spi_flash_ce_n_o  = 1'b1;
        spi_ram_ce_n_o    = 1'b1;
        if (gnt0_o) begin
            spi_txn_start_o   = txn_start0_i;
            spi_data_tx_o     = data_tx0_i;
            spi_force_clock_o = force_clock0_i;
            spi_flash_ce_n_o  = flash_ce_n0_i;
            spi_ram_ce_n_o    = ram_ce_n0_i;
        end else if (gnt1_o) begin
            spi_txn_start_o   = txn_start1_i;
            spi_data_tx_o     = data_tx1_i;
            spi_force_clock_o = force_clock1_i;
            spi_flash_ce_n_o  = flash_ce_n1_i;
            spi_ram_ce_n_o    = ram_ce_n1_i;
        end
    end

    // Next-state: arbitration, busy tracking, watchdog
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        stale_d   = stale_q & {req1_i, req0_i};
        pick1     = 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif

        if (own_start) begin
            busy_d = 1'b1;
        end else if (spi_txn_done_i) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (eff_req == 2'b11) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    pick1 = ~last_q;
`else
                    pick1 = 1'b0;
`endif
                end else begin
                    pick1 = eff_req[1];
                end
                if (|eff_req) begin
                    state_d = pick1 ? ST_GRANT1 : ST_GRANT0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    last_d  = pick1;
`endif
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (own_start || own_force || spi_txn_done_i) begin
                    cnt_d = '0;
                end else if (!busy_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                // A completing transfer lets a dropped request release right away
                if (!own_req && (!busy_q || (spi_txn_done_i && !own_start))) begin
                    state_d = ST_RELEASE;
                end else if (!busy_q && (cnt_q == CNT_LAST) && !own_start
                             && !own_force && !spi_txn_done_i) begin
                    state_d          = ST_RELEASE;
                    timeout_d        = 1'b1;
                    stale_d[own_sel] = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            stale_q   <= 2'b00;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            stale_q   <= stale_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against an ownership-level reference model.
module tb_spi_bus_arbiter;
    localparam int unsigned T = 16;

    typedef struct packed {
        logic       req0, req1, st0, st1, f0, f1, fce0, fce1, rce0, rce1, done;
        logic [7:0] d0, d1, rx;
    } in_t;

    typedef struct packed {
        logic       gnt0, gnt1, done0, done1;
        logic [7:0] rx;
        logic       st;
        logic [7:0] tx;
        logic       fc, fce, rce, to;
    } out_t;

    logic       clk, rst_n;
    logic       req0, req1, gnt0, gnt1, txn_start0, txn_start1;
    logic [7:0] data_tx0, data_tx1;
    logic       force_clock0, force_clock1, flash_ce_n0, flash_ce_n1, ram_ce_n0, ram_ce_n1;
    logic       txn_done0, txn_done1;
    logic [7:0] spi_data_rx_out, spi_data_tx, spi_data_rx;
    logic       spi_txn_start, spi_force_clock, spi_flash_ce_n, spi_ram_ce_n;
    logic       spi_txn_done, timeout;

    spi_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .gnt0_o(gnt0), .gnt1_o(gnt1),
        .txn_start0_i(txn_start0), .txn_start1_i(txn_start1),
        .data_tx0_i(data_tx0), .data_tx1_i(data_tx1),
        .force_clock0_i(force_clock0), .force_clock1_i(force_clock1),
        .flash_ce_n0_i(flash_ce_n0), .flash_ce_n1_i(flash_ce_n1),
        .ram_ce_n0_i(ram_ce_n0), .ram_ce_n1_i(ram_ce_n1),
        .txn_done0_o(txn_done0), .txn_done1_o(txn_done1),
        .spi_data_rx_o(spi_data_rx_out),
        .spi_txn_start_o(spi_txn_start), .spi_data_tx_o(spi_data_tx),
        .spi_force_clock_o(spi_force_clock),
        .spi_flash_ce_n_o(spi_flash_ce_n), .spi_ram_ce_n_o(spi_ram_ce_n),
        .spi_txn_done_i(spi_txn_done), .spi_data_rx_i(spi_data_rx),
        .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0, n_fail = 0, cyc = 0;
    out_t exp_q[$];
    int   glog[$];
    int   g0cyc = 0, g1cyc = 0, g1rise = 0, n_done0 = 0, n_done1 = 0, n_to = 0, bad_ce = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    in_t  cur;

    // Reference model: who owns the bus, forced gap, in-flight byte, idle time, stale requests
    int   m_owner, m_idle, m_last;
    bit   m_gap, m_busy, m_to;
    bit   m_stale[2];

    function automatic void model_reset();
        m_owner = -1; m_idle = 0; m_last = 1;
        m_gap = 0; m_busy = 0; m_to = 0;
        m_stale[0] = 0; m_stale[1] = 0;
    endfunction

    function automatic out_t expect_out(in_t v);
        out_t o;
        o = '0;
        o.fce = 1'b1; o.rce = 1'b1; o.rx = v.rx; o.to = m_to;
        if (m_owner == 0) begin
            o.gnt0 = 1'b1; o.done0 = v.done; o.st = v.st0; o.tx = v.d0;
            o.fc = v.f0; o.fce = v.fce0; o.rce = v.rce0;
        end else if (m_owner == 1) begin
            o.gnt1 = 1'b1; o.done1 = v.done; o.st = v.st1; o.tx = v.d1;
            o.fc = v.f1; o.fce = v.fce1; o.rce = v.rce1;
        end
        return o;
    endfunction

    function automatic void model_step(in_t v);
        bit rq[2];
        bit st, fo, fired;
        int o;
        rq[0] = v.req0; rq[1] = v.req1;
        fired = 0;
        o = m_owner;
        for (int n = 0; n < 2; n++) if (!rq[n]) m_stale[n] = 0;
        if (o >= 0) begin
            st = (o == 1) ? v.st1 : v.st0;
            fo = (o == 1) ? v.f1 : v.f0;
            if (!rq[o] && (!m_busy || (v.done && !st))) begin
                m_owner = -1; m_gap = 1;
            end else if (!m_busy && m_idle == int'(T) - 1 && !st && !fo && !v.done) begin
                m_owner = -1; m_gap = 1; m_stale[o] = 1; fired = 1;
            end
            if (st || fo || v.done) m_idle = 0;
            else if (!m_busy) m_idle++;
            if (st) m_busy = 1;
            else if (v.done) m_busy = 0;
        end else begin
            if (v.done) m_busy = 0;
            if (m_gap) m_gap = 0;
            else begin
                bit w0, w1;
                w0 = rq[0] && !m_stale[0];
                w1 = rq[1] && !m_stale[1];
                if (w0 && w1) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    m_owner = (m_last == 1) ? 0 : 1;
`else
                    m_owner = 0;
`endif
                end else if (w0) m_owner = 0;
                else if (w1) m_owner = 1;
                if (m_owner >= 0) begin
                    m_last = m_owner; m_idle = 0;
                end
            end
        end
        m_to = fired;
    endfunction

    task automatic apply(in_t v);
        req0 = v.req0; req1 = v.req1; txn_start0 = v.st0; txn_start1 = v.st1;
        force_clock0 = v.f0; force_clock1 = v.f1;
        flash_ce_n0 = v.fce0; flash_ce_n1 = v.fce1; ram_ce_n0 = v.rce0; ram_ce_n1 = v.rce1;
        spi_txn_done = v.done; data_tx0 = v.d0; data_tx1 = v.d1; spi_data_rx = v.rx;
    endtask

    // One clock of stimulus: drive, predict, advance the model, clear pulses
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        apply(cur);
        exp_q.push_back(expect_out(cur));
        model_step(cur);
        cur.st0 = 0; cur.st1 = 0; cur.f0 = 0; cur.f1 = 0; cur.done = 0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected output set per cycle and tallies observed events
    always @(negedge clk) begin
        out_t e, a;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {gnt0, gnt1, txn_done0, txn_done1, spi_data_rx_out, spi_txn_start,
                     spi_data_tx, spi_force_clock, spi_flash_ce_n, spi_ram_ce_n, timeout};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard cycle %0d: got %h, expected %h", cyc, a, e);
                end
            end
            if (gnt0) g0cyc++;
            if (gnt1) g1cyc++;
            if (gnt0 && !prev0) glog.push_back(0);
            if (gnt1 && !prev1) begin glog.push_back(1); g1rise++; end
            if (txn_done0) n_done0++;
            if (txn_done1) n_done1++;
            if (timeout) n_to++;
            if (!gnt0 && !gnt1 && (!spi_flash_ce_n || !spi_ram_ce_n)) bad_ce++;
            prev0 = gnt0; prev1 = gnt1;
        end else begin
            prev0 = 1'b0; prev1 = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] bytes [3];
        int b0, b1, base, bt, w, o;
        bytes[0] = 8'h9F; bytes[1] = 8'h00; bytes[2] = 8'h00;
        cur = '0;
        cur.fce0 = 1; cur.fce1 = 1; cur.rce0 = 1; cur.rce1 = 1;
        apply(cur);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_start", int'(spi_txn_start), 0);
        chk("rst_tx", int'(spi_data_tx), 0);
        chk("rst_flash_ce", int'(spi_flash_ce_n), 1);
        chk("rst_ram_ce", int'(spi_ram_ce_n), 1);
        chk("rst_timeout", int'(timeout), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Single requester, three bytes
        b0 = n_done0; b1 = n_done1;
        cur.req1 = 1; cur.fce1 = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            cur.st1 = 1; cur.d1 = bytes[i];
            step(); step(); step();
            cur.done = 1; cur.rx = 8'($urandom);
            step();
        end
        cur.req1 = 0; cur.fce1 = 1;
        repeat (3) step();
        settle();
        chk("single_done1_pulses", n_done1 - b1, 3);
        chk("single_done0_pulses", n_done0 - b0, 0);

        // Simultaneous requests, three ownership rounds
        glog.delete();
        cur.req0 = 1; cur.req1 = 1;
        for (int r = 0; r < 3; r++) begin
            w = 0;
            while (m_owner < 0 && w < 10) begin step(); w++; end
            chk("tie_grant_wait", int'(w < 10), 1);
            o = m_owner;
            repeat (4) step();
            if (o == 0) cur.req0 = 0; else cur.req1 = 0;
            step();
            cur.req0 = 1; cur.req1 = 1;
        end
        cur.req0 = 0; cur.req1 = 0;
        repeat (4) step();
        settle();
        chk("tie_rounds", glog.size(), 3);
        for (int i = 0; i < glog.size() && i < 3; i++) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
            chk($sformatf("tie_owner_%0d", i), glog[i], (i == 1) ? 1 : 0);
`else
            chk($sformatf("tie_owner_%0d", i), glog[i], 0);
`endif
        end

        // Request drops while a byte is in flight
        base = g0cyc;
        cur.req0 = 1; step();
        cur.st0 = 1; cur.d0 = 8'($urandom); step();
        cur.req0 = 0; step();
        repeat (6) step();
        cur.done = 1; step();
        repeat (3) step();
        settle();
        chk("busy_hold_gnt_cycles", g0cyc - base, 9);

        // Watchdog, stale request, long transfer
        bt = n_to; base = g1cyc;
        cur.req1 = 1;
        repeat (30) step();
        settle();
        chk("wd_timeout_pulses", n_to - bt, 1);
        chk("wd_gnt_cycles", g1cyc - base, int'(T));
        base = g1rise;
        cur.req1 = 0; step();
        cur.req1 = 1; repeat (3) step();
        settle();
        chk("wd_regrant", g1rise - base, 1);
        bt = n_to;
        cur.st1 = 1; step();
        repeat (39) step();
        cur.done = 1; step();
        repeat (5) step();
        settle();
        chk("wd_long_xfer_timeouts", n_to - bt, 0);
        chk("wd_long_xfer_owned", int'(gnt1), 1);
        cur.req1 = 0;
        repeat (3) step();

        // Random traffic: busy phase, then a quiet phase that lets the watchdog fire
        for (int ph = 0; ph < 2; ph++) begin
            repeat (2000) begin
                if ($urandom_range(11) == 0) cur.req0 = ~cur.req0;
                if ($urandom_range(11) == 0) cur.req1 = ~cur.req1;
                cur.st0  = (ph == 0) ? ($urandom_range(5) == 0) : ($urandom_range(39) == 0);
                cur.st1  = (ph == 0) ? ($urandom_range(5) == 0) : ($urandom_range(39) == 0);
                cur.f0   = ($urandom_range(19) == 0) && (ph == 0);
                cur.f1   = ($urandom_range(19) == 0) && (ph == 0);
                cur.done = (ph == 0) ? ($urandom_range(4) == 0) : ($urandom_range(29) == 0);
                cur.fce0 = 1'($urandom); cur.fce1 = 1'($urandom);
                cur.rce0 = 1'($urandom); cur.rce1 = 1'($urandom);
                cur.d0 = 8'($urandom); cur.d1 = 8'($urandom); cur.rx = 8'($urandom);
                step();
            end
        end
        cur = '0;
        cur.fce0 = 1; cur.fce1 = 1; cur.rce0 = 1; cur.rce1 = 1;
        cur.done = 1; step();
        repeat (4) step();

        // Asynchronous reset while port 1 owns the bus mid-transfer
        cur.req1 = 1; cur.fce1 = 0; cur.rce1 = 0;
        step();
        cur.st1 = 1; cur.d1 = 8'h3C; step();
        step();
        @(posedge clk); #1;
        cur.st1 = 1; cur.d1 = 8'hA5;
        apply(cur);
        #1;
        chk("pre_rst_start", int'(spi_txn_start), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_gnt1", int'(gnt1), 0);
        chk("async_rst_start", int'(spi_txn_start), 0);
        chk("async_rst_flash_ce", int'(spi_flash_ce_n), 1);
        chk("async_rst_ram_ce", int'(spi_ram_ce_n), 1);
        chk("async_rst_tx", int'(spi_data_tx), 0);
        cur = '0;
        cur.fce0 = 1; cur.fce1 = 1; cur.rce0 = 1; cur.rce1 = 1;
        apply(cur);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        glog.delete();
        cur.req0 = 1; cur.req1 = 1;
        repeat (3) step();
        settle();
        chk("post_rst_tie_n", glog.size(), 1);
        if (glog.size() > 0) chk("post_rst_tie_owner", glog[0], 0);
        cur.req0 = 0; cur.req1 = 0;
        repeat (4) step();
        settle();
        chk("ce_low_without_grant", bad_ce, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
